sample_stream_buffer: RTL and testbench
=======================================

// Module: sample_stream_buffer
// PURPOSE
//  Sits between the note-to-sample superposition stage and the audio codec interface.
//  Paces sample production by pulsing generate_next_sample and capturing in_sample on
//  new_sample_ready. Buffers samples in a DEPTH-entry FIFO.
//  Applies volume attenuation and mute, and presents one sample per codec_ready strobe.
// PARAMETERS
//  DEPTH    8     FIFO entries; power of two, 2..64
//  TIMEOUT  1023  cycles to wait for new_sample_ready before re-requesting
// PORTS
//  clk                   in   1   system clock
//  reset                 in   1   asynchronous, active-low; 0 = reset
//  in_sample             in   16  signed sample from superposition
//  new_sample_ready      in   1   1-cycle strobe: in_sample valid
//  generate_next_sample  out  1   1-cycle request to superposition
//  codec_ready           in   1   1-cycle strobe: codec consumes a sample
//  volume                in   3   attenuation, arithmetic right shift 0..7
//  mute                  in   1   1 = force output samples to zero
//  codec_sample          out  16  signed sample to codec, registered
//  fill_level            out  log2(DEPTH)+1  current FIFO occupancy
//  underflow_count       out  8   saturating count of pops attempted while empty
// BEHAVIOUR
//  Reset (reset=0, async): FIFO empty, state IDLE, timer=0. Outputs go low immediately:
//   generate_next_sample=0, codec_sample=0, fill_level=0, underflow_count=0.
//  Request FSM, 2 states:
//   IDLE: if fill_level<DEPTH, drive generate_next_sample=1 for one cycle (registered),
//    clear timer, go to WAIT. Otherwise stay in IDLE with no request.
//    new_sample_ready received while in IDLE is ignored and drops the sample.
//   WAIT: on new_sample_ready, write in_sample to the FIFO tail and go to IDLE.
//    Otherwise increment timer. When timer reaches TIMEOUT, go to IDLE (a re-request follows).
//   At most one outstanding request at any time, so the FIFO cannot overflow.
//   Back-to-back throughput: one sample per 2 cycles plus the superposition latency.
//   First request fires on the 1st rising edge after reset deasserts.
//  Output side:
//   On codec_ready with FIFO not empty: pop the head. On the next edge,
//    codec_sample = mute ? 0 : (head >>> volume). Latency 1 cycle.
//   On codec_ready with FIFO empty: codec_sample holds its last value.
//    underflow_count increments and saturates at 255.
//   codec_sample changes only on codec_ready. volume and mute are sampled at the pop.
//  Arithmetic: two's-complement 16b; sign-preserving shift (0x8000>>>1=0xC000, -1>>>n=-1).
//  Simultaneous write and pop:
//   Both take effect and fill_level is unchanged.
//   If the FIFO is empty, the pop underflows; there is no bypass. The write lands and fill becomes 1.
//  Pointers are log2(DEPTH) bits and wrap modulo DEPTH. fill_level is registered and exact.
//  Reset asserted mid-WAIT: the outstanding request is abandoned. A late new_sample_ready
//   after release arrives while in IDLE/new WAIT of a fresh request. Do not rely on it.
// TESTING
//  1 Release reset; model answers each request 3 cycles later with samples 1,2,3...
//    -> fill_level climbs to 8, then generate_next_sample stays 0.
//  2 Head=0x4000, volume=2, codec_ready -> codec_sample=0x1000 next cycle.
//    Head=0x8000, volume=1 -> 0xC000. Mute=1 -> 0x0000. Popped in order 1,2,3.
//  3 Empty FIFO, no answers, 300 codec_ready pulses -> codec_sample held,
//    underflow_count=255 (saturated).
//  4 Model never answers -> generate_next_sample pulses repeat at a period of TIMEOUT+2 cycles.
//  5 fill_level=4, codec_ready coincides with new_sample_ready -> fill_level stays 4, FIFO order kept.
//  6 reset=0 during WAIT with FIFO at 5 -> all outputs 0 the same cycle.
//    After release, fill_level=0 and a new request fires on the first edge.

Source files
------------

// File: rtl/sample_stream_buffer.sv
// rtl/sample_stream_buffer.sv - request-paced sample FIFO with volume/mute stage toward the codec
module sample_stream_buffer #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic signed [15:0]         in_sample,
    input  logic                       new_sample_ready,
    output logic                       generate_next_sample,
    input  logic                       codec_ready,
    input  logic [2:0]                 volume,
    input  logic                       mute,
    output logic signed [15:0]         codec_sample,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic [7:0]                 underflow_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   FULL_LEVEL  = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TIMER_LIMIT = TW'(TIMEOUT);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t             state;
    logic [TW-1:0]      timer;
    logic signed [15:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               fifo_empty;
    logic               do_write;
    logic               do_pop;

    assign fifo_empty = (fill_level == '0);
    // Only one request is ever outstanding, so the full guard is a safety net.
    assign do_write   = (state == S_WAIT) && new_sample_ready && (fill_level != FULL_LEVEL);
    assign do_pop     = codec_ready && !fifo_empty;

    // Request pacing: one registered request pulse, then wait for the answer or give up.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                <= S_IDLE;
            timer                <= '0;
            generate_next_sample <= 1'b0;
        end else begin
            generate_next_sample <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (fill_level < FULL_LEVEL) begin
                        generate_next_sample <= 1'b1;
                        timer                <= '0;
                        state                <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (new_sample_ready) begin
                        state <= S_IDLE;
                    end else if (timer == TIMER_LIMIT) begin
                        state <= S_IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Sample storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= in_sample;
        end
    end

    // Pointers wrap naturally at DEPTH; occupancy tracks write/pop pairs exactly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_write, do_pop})
                2'b10:   fill_level <= fill_level + (AW + 1)'(1);
                2'b01:   fill_level <= fill_level - (AW + 1)'(1);
                default: fill_level <= fill_level;
            endcase
        end
    end

    // Codec side: attenuate/mute at the pop, hold the sample and count misses when empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            codec_sample    <= '0;
            underflow_count <= '0;
        end else if (codec_ready) begin
            if (!fifo_empty) begin
                codec_sample <= mute ? 16'sh0000 : (mem[rd_ptr] >>> volume);
            end else if (underflow_count != 8'hFF) begin
                underflow_count <= underflow_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_sample_stream_buffer.sv
// tb/tb_sample_stream_buffer.sv - randomized self-checking bench for sample_stream_buffer
module tb_sample_stream_buffer;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 1023;

    logic        clk;
    logic        reset;
    logic [15:0] in_sample;
    logic        new_sample_ready;
    logic        generate_next_sample;
    logic        codec_ready;
    logic [2:0]  volume;
    logic        mute;
    logic [15:0] codec_sample;
    logic [3:0]  fill_level;
    logic [7:0]  underflow_count;

    sample_stream_buffer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk                  (clk),
        .reset                (reset),
        .in_sample            (in_sample),
        .new_sample_ready     (new_sample_ready),
        .generate_next_sample (generate_next_sample),
        .codec_ready          (codec_ready),
        .volume               (volume),
        .mute                 (mute),
        .codec_sample         (codec_sample),
        .fill_level           (fill_level),
        .underflow_count      (underflow_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] model_q[$];
    logic [15:0] src_q[$];
    logic [15:0] exp_sample = 16'h0;
    int          exp_uf = 0;
    int          mode = 1;          // 0 silent, 1 auto answer after 3 cycles, 2 manual
    bit          outstanding = 1'b0;
    int          cd = 0;
    int          cyc = 0;
    int          gen_times[$];
    logic [15:0] held;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] next_sample();
        if (src_q.size() > 0) return src_q.pop_front();
        return 16'($urandom);
    endfunction

    // One clock: drive at the falling edge, model the rising edge, check 1 time unit later.
    task automatic tick(input bit cr, input logic [2:0] vol, input bit mu, input bit force_ans);
        bit                 ans;
        logic [15:0]        s;
        logic signed [15:0] hs;
        ans = 1'b0;
        s   = 16'h0;
        if (outstanding) begin
            if (mode == 1) begin
                cd--;
                if (cd <= 0) ans = 1'b1;
            end else if (mode == 2 && force_ans) begin
                ans = 1'b1;
            end
        end
        if (ans) begin
            s = next_sample();
            outstanding = 1'b0;
        end
        in_sample        = s;
        new_sample_ready = ans;
        codec_ready      = cr;
        volume           = vol;
        mute             = mu;
        @(posedge clk);
        cyc++;
        if (cr) begin
            if (model_q.size() > 0) begin
                hs = model_q.pop_front();
                exp_sample = mu ? 16'h0 : 16'(hs >>> vol);
            end else if (exp_uf < 255) begin
                exp_uf++;
            end
        end
        if (ans) model_q.push_back(s);
        #1;
        chk("codec_sample", codec_sample, exp_sample);
        chk("fill_level", fill_level, model_q.size());
        chk("underflow_count", underflow_count, exp_uf);
        if (generate_next_sample === 1'b1) begin
            gen_times.push_back(cyc);
            if (mode != 0) begin
                chk("single_outstanding", outstanding, 0);
                outstanding = 1'b1;
                cd = 3;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        in_sample = 16'h0; new_sample_ready = 1'b0; codec_ready = 1'b0;
        volume = 3'd0; mute = 1'b0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("reset_gen", generate_next_sample, 0);
        chk("reset_codec", codec_sample, 0);
        chk("reset_fill", fill_level, 0);
        chk("reset_uf", underflow_count, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Fill to DEPTH with auto answers; first request on the first edge.
        src_q = '{16'h4000, 16'h8000, 16'h0007, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
        mode = 1;
        tick(0, 0, 0, 0);
        chk("first_request", generate_next_sample, 1);
        for (int i = 0; i < 200 && model_q.size() < DEPTH; i++) tick(0, 0, 0, 0);
        chk("fill_reached_depth", fill_level, DEPTH);
        for (int i = 0; i < 20; i++) begin
            tick(0, 0, 0, 0);
            chk("no_request_when_full", generate_next_sample, 0);
        end

        // Attenuation, mute and ordering.
        tick(1, 3'd2, 0, 0); chk("shift_0x4000_by2", codec_sample, 16'h1000);
        tick(1, 3'd1, 0, 0); chk("shift_0x8000_by1", codec_sample, 16'hC000);
        tick(1, 3'd0, 1, 0); chk("mute_zero", codec_sample, 16'h0000);
        tick(1, 3'd0, 0, 0); chk("order_1", codec_sample, 16'h0001);
        tick(1, 3'd0, 0, 0); chk("order_2", codec_sample, 16'h0002);
        tick(1, 3'd0, 0, 0); chk("order_3", codec_sample, 16'h0003);
        for (int i = 0; i < 120; i++)
            tick(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0), 0);

        // Write and pop on the same edge at fill 4.
        mode = 2;
        for (int i = 0; i < 200 && model_q.size() != 4; i++)
            tick(model_q.size() > 4, 0, 0, model_q.size() < 4);
        chk("fill_at_4", fill_level, 4);
        for (int i = 0; i < 20 && !outstanding; i++) tick(0, 0, 0, 0);
        chk("request_pending", outstanding, 1);
        tick(1, 3'd3, 0, 1);
        chk("fill_held_on_simul", fill_level, 4);
        for (int i = 0; i < 20 && model_q.size() > 0; i++) tick(1, 3'($urandom_range(0, 7)), 0, 0);
        chk("drained", fill_level, 0);

        // Underflow saturation with no answers, then retry period.
        mode = 0;
        outstanding = 1'b0;
        gen_times.delete();
        held = exp_sample;
        for (int i = 0; i < 300; i++) begin
            tick(1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 0);
            tick(0, 0, 0, 0);
        end
        chk("uf_saturated", underflow_count, 255);
        chk("codec_held", codec_sample, held);
        for (int i = 0; i < 3000 && gen_times.size() < 3; i++) tick(0, 0, 0, 0);
        chk("retry_pulses_seen", gen_times.size() >= 3, 1);
        for (int k = 1; k < gen_times.size(); k++)
            chk("retry_period", gen_times[k] - gen_times[k-1], TIMEOUT + 2);

        // Reset in the middle of a wait with 5 samples buffered.
        mode = 1;
        outstanding = 1'b0;
        for (int i = 0; i < 3000 && model_q.size() < 5; i++) tick(0, 0, 0, 0);
        chk("fill_at_5", fill_level, 5);
        mode = 2;
        for (int i = 0; i < 10 && !outstanding; i++) tick(0, 0, 0, 0);
        chk("waiting_before_reset", outstanding, 1);
        reset = 1'b0;
        #1;
        chk("midreset_gen", generate_next_sample, 0);
        chk("midreset_codec", codec_sample, 0);
        chk("midreset_fill", fill_level, 0);
        chk("midreset_uf", underflow_count, 0);
        model_q.delete();
        exp_sample = 16'h0;
        exp_uf = 0;
        outstanding = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick(0, 0, 0, 0);
        chk("request_after_reset", generate_next_sample, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
